gmii_rx_frame: RTL and testbench

GMII_RX_FRAME -- requirements
Module: gmii_rx_frame

---
 rtl/gmii_rx_frame_pkg.sv | 27 ++
 rtl/gmii_rx_frame_crc32_d8.sv | 28 ++
 rtl/gmii_rx_frame.sv | 140 ++++++++++++++
 tb/tb_gmii_rx_frame.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/gmii_rx_frame_pkg.sv
// Shared types and constants for the GMII receive frame extractor.
package gmii_rx_frame_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_e;

  localparam int unsigned LEN_W         = 11;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned MIN_FRAME_LEN = 64;
  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [LEN_W-1:0] LEN_SAT  = '1;
  localparam logic [CNT_W-1:0] CNT_SAT  = '1;

  // The CRC register shifts LSB-first; the residue constant is in MSB-first order.
  function automatic logic [31:0] bit_rev32(input logic [31:0] x);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = x[31-i];
    return r;
  endfunction

endpackage

// File: rtl/gmii_rx_frame_crc32_d8.sv
// Reflected CRC-32 (0x04C11DB7), one byte per cycle, with enable and synchronous clear.
module crc32_d8
  import gmii_rx_frame_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        clr,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_nxt_c;

  always_comb begin
    crc_nxt_c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      crc_nxt_c = crc_nxt_c[0] ? ((crc_nxt_c >> 1) ^ 32'hEDB88320) : (crc_nxt_c >> 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   crc <= '1;
    else if (clr) crc <= '1;
    else if (en)  crc <= crc_nxt_c;
  end

endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive frame extractor: strips preamble/SFD, streams DA..FCS with sop/eop, length and counters.
// Optional FCS checking is built when GMII_RX_CRC_CHECK_EN is defined.
module gmii_rx_frame
  import gmii_rx_frame_pkg::*;
#(
  parameter int unsigned MAX_FRAME_LEN = 1522
) (
  input  logic        gmii_rx_clk,
  input  logic        rst_n,
  input  logic        gmii_rx_dv,
  input  logic [7:0]  gmii_rxd,
  output logic        rx_valid,
  output logic [7:0]  rx_data,
  output logic        rx_sop,
  output logic        rx_eop,
  output logic [10:0] rx_len,
  output logic        rx_err_len,
  output logic        rx_err_crc,
  output logic [15:0] rx_frame_cnt,
  output logic [15:0] rx_err_cnt
);

  state_e            state, state_nxt;
  logic              dv_q;
  logic [7:0]        rxd_q;
  logic [7:0]        hold;
  logic [LEN_W-1:0]  byte_cnt;
  logic              load_c, emit_c, last_c, start_c;
  logic              len_bad_c, crc_bad_c;

  // Input stage
  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_q  <= 1'b0;
      rxd_q <= '0;
    end else begin
      dv_q  <= gmii_rx_dv;
      rxd_q <= gmii_rxd;
    end
  end

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // A byte is emitted one cycle after it is held, so byte_cnt==0 means nothing is held yet.
  always_comb begin
    state_nxt = state;
    load_c    = 1'b0;
    emit_c    = 1'b0;
    last_c    = 1'b0;
    start_c   = 1'b0;
    case (state)
      IDLE: begin
        if (dv_q) state_nxt = (rxd_q == PREAMBLE_BYTE) ? PREAMBLE : DROP;
      end
      PREAMBLE: begin
        if (!dv_q) begin
          state_nxt = IDLE;
        end else if (rxd_q == SFD_BYTE) begin
          state_nxt = DATA;
          start_c   = 1'b1;
        end else if (rxd_q != PREAMBLE_BYTE) begin
          state_nxt = DROP;
        end
      end
      DATA: begin
        if (dv_q) begin
          load_c = 1'b1;
          emit_c = (byte_cnt != '0);
        end else begin
          state_nxt = IDLE;
          emit_c    = (byte_cnt != '0);
          last_c    = (byte_cnt != '0);
        end
      end
      DROP: begin
        if (!dv_q) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign len_bad_c = (byte_cnt < LEN_W'(MIN_FRAME_LEN)) || (byte_cnt > LEN_W'(MAX_FRAME_LEN));

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold         <= '0;
      byte_cnt     <= '0;
      rx_valid     <= 1'b0;
      rx_data      <= '0;
      rx_sop       <= 1'b0;
      rx_eop       <= 1'b0;
      rx_len       <= '0;
      rx_err_len   <= 1'b0;
      rx_frame_cnt <= '0;
      rx_err_cnt   <= '0;
    end else begin
      if (start_c)                            byte_cnt <= '0;
      else if (load_c && byte_cnt != LEN_SAT) byte_cnt <= byte_cnt + LEN_W'(1);
      if (load_c) hold <= rxd_q;
      rx_valid   <= emit_c;
      rx_data    <= emit_c ? hold : 8'd0;
      rx_sop     <= emit_c && (byte_cnt == LEN_W'(1));
      rx_eop     <= last_c;
      rx_len     <= last_c ? byte_cnt : '0;
      rx_err_len <= last_c && len_bad_c;
      if (last_c) begin
        if (rx_frame_cnt != CNT_SAT) rx_frame_cnt <= rx_frame_cnt + CNT_W'(1);
        if ((len_bad_c || crc_bad_c) && rx_err_cnt != CNT_SAT) rx_err_cnt <= rx_err_cnt + CNT_W'(1);
      end
    end
  end

`ifdef GMII_RX_CRC_CHECK_EN
  logic [31:0] crc_q;

  // CRC covers exactly the bytes loaded into the hold register, FCS included.
  crc32_d8 u_crc (
    .clk   (gmii_rx_clk),
    .rst_n (rst_n),
    .en    (load_c),
    .clr   (start_c),
    .data  (rxd_q),
    .crc   (crc_q)
  );

  assign crc_bad_c = (bit_rev32(crc_q) != CRC_RESIDUE);

  always_ff @(posedge gmii_rx_clk or negedge rst_n) begin
    if (!rst_n) rx_err_crc <= 1'b0;
    else        rx_err_crc <= last_c && crc_bad_c;
  end
`else
  assign crc_bad_c  = 1'b0;
  assign rx_err_crc = 1'b0;
`endif

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Scoreboard bench for gmii_rx_frame: frames are generated with their own FCS and expectations queued as bytes are driven.
module tb_gmii_rx_frame;

  localparam int unsigned MAX_LEN = 1522;

  typedef logic [7:0] byte_q_t [$];
  typedef struct {
    logic [7:0]  d;
    logic        sop;
    logic        eop;
    logic [10:0] len;
    logic        el;
    logic        ec;
    logic [15:0] fc;
    logic [15:0] ecn;
    int          cyc;
  } exp_t;

  logic        gmii_rx_clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gmii_rx_dv = 1'b0;
  logic [7:0]  gmii_rxd = 8'd0;
  logic        rx_valid, rx_sop, rx_eop, rx_err_len, rx_err_crc;
  logic [7:0]  rx_data;
  logic [10:0] rx_len;
  logic [15:0] rx_frame_cnt, rx_err_cnt;

  exp_t        sb[$];
  exp_t        mon_it;
  int          n_tests = 0;
  int          n_fail = 0;
  int          cyc = 0;
  logic [15:0] exp_fc = 0;
  logic [15:0] exp_ec = 0;
  byte_q_t     fr;

  gmii_rx_frame #(.MAX_FRAME_LEN(MAX_LEN)) dut (
    .gmii_rx_clk (gmii_rx_clk),
    .rst_n       (rst_n),
    .gmii_rx_dv  (gmii_rx_dv),
    .gmii_rxd    (gmii_rxd),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .rx_sop      (rx_sop),
    .rx_eop      (rx_eop),
    .rx_len      (rx_len),
    .rx_err_len  (rx_err_len),
    .rx_err_crc  (rx_err_crc),
    .rx_frame_cnt(rx_frame_cnt),
    .rx_err_cnt  (rx_err_cnt)
  );

  always #5 gmii_rx_clk = ~gmii_rx_clk;
  always @(posedge gmii_rx_clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic drive(input logic dv, input logic [7:0] d);
    @(posedge gmii_rx_clk);
    #1;
    gmii_rx_dv = dv;
    gmii_rxd   = d;
  endtask

  task automatic make_frame(input int n, input bit flip, output byte_q_t f);
    logic [31:0] c;
    c = '1;
    f.delete();
    for (int i = 0; i < n - 4; i++) begin
      f.push_back(8'($urandom_range(0, 255)));
      c = crc_upd(c, f[i]);
    end
    c = ~c;
    for (int i = 0; i < 4; i++) f.push_back(c[8*i +: 8]);
    if (flip) f[10] = f[10] ^ 8'h01;
  endtask

  task automatic preamble();
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
  endtask

  task automatic send_frame(input byte_q_t f, input int gap);
    int          n;
    logic [31:0] c;
    logic        el, ec;
    exp_t        it;
    n = f.size();
    c = '1;
    foreach (f[i]) c = crc_upd(c, f[i]);
    el = (n < 64) || (n > int'(MAX_LEN));
`ifdef GMII_RX_CRC_CHECK_EN
    ec = (c != 32'hDEBB20E3);
`else
    ec = 1'b0;
`endif
    exp_fc = (exp_fc == 16'hFFFF) ? exp_fc : exp_fc + 16'd1;
    if ((el || ec) && exp_ec != 16'hFFFF) exp_ec = exp_ec + 16'd1;
    preamble();
    for (int i = 0; i < n; i++) begin
      drive(1'b1, f[i]);
      it.d   = f[i];
      it.sop = (i == 0);
      it.eop = (i == n - 1);
      it.len = 11'((n > 2047) ? 2047 : n);
      it.el  = el;
      it.ec  = ec;
      it.fc  = exp_fc;
      it.ecn = exp_ec;
      it.cyc = cyc;
      sb.push_back(it);
    end
    for (int i = 0; i < gap; i++) drive(1'b0, 8'h00);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge gmii_rx_clk);
    check_eq(tag, 32'(sb.size()), 32'd0);
  endtask

  // Scoreboard monitor, sampled on the falling edge
  always @(negedge gmii_rx_clk) begin
    if (rst_n && rx_valid) begin
      if (sb.size() == 0) begin
        check_eq("spurious_valid", 32'(rx_valid), 32'd0);
      end else begin
        mon_it = sb.pop_front();
        check_eq("data", 32'(rx_data), 32'(mon_it.d));
        check_eq("sop", 32'(rx_sop), 32'(mon_it.sop));
        check_eq("eop", 32'(rx_eop), 32'(mon_it.eop));
        check_eq("latency", 32'(cyc - mon_it.cyc), 32'd3);
        if (mon_it.eop) begin
          check_eq("len", 32'(rx_len), 32'(mon_it.len));
          check_eq("err_len", 32'(rx_err_len), 32'(mon_it.el));
          check_eq("err_crc", 32'(rx_err_crc), 32'(mon_it.ec));
          check_eq("frame_cnt", 32'(rx_frame_cnt), 32'(mon_it.fc));
          check_eq("err_cnt", 32'(rx_err_cnt), 32'(mon_it.ecn));
        end
      end
    end
  end

  initial begin
    exp_t it;
    repeat (3) drive(1'b0, 8'h00);
    check_eq("rst_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_data", 32'(rx_data), 32'd0);
    check_eq("rst_frame_cnt", 32'(rx_frame_cnt), 32'd0);
    check_eq("rst_err_cnt", 32'(rx_err_cnt), 32'd0);
    @(posedge gmii_rx_clk); #1 rst_n = 1'b1;
    repeat (2) drive(1'b0, 8'h00);

    make_frame(64, 1'b0, fr);  send_frame(fr, 1);
    make_frame(64, 1'b1, fr);  send_frame(fr, 1);
    make_frame(40, 1'b0, fr);  send_frame(fr, 1);

    // Burst without preamble, then a clean frame after one idle cycle
    drive(1'b1, 8'h12);
    for (int i = 0; i < 29; i++) drive(1'b1, 8'($urandom_range(0, 255)));
    drive(1'b0, 8'h00);
    make_frame(64, 1'b0, fr);  send_frame(fr, 1);

    make_frame(100, 1'b0, fr); send_frame(fr, 1);
    make_frame(100, 1'b0, fr); send_frame(fr, 1);

    fr.delete(); fr.push_back(8'hA5); send_frame(fr, 1);

    // SFD followed immediately by dv low: nothing emitted, counters unchanged
    preamble();
    drive(1'b0, 8'h00);
    // Corrupted preamble is dropped
    drive(1'b1, 8'h55); drive(1'b1, 8'h55); drive(1'b1, 8'h33);
    for (int i = 0; i < 10; i++) drive(1'b1, 8'hD5);
    drive(1'b0, 8'h00);

    make_frame(1600, 1'b0, fr); send_frame(fr, 2);
    drain("drain_pre_reset");
    check_eq("cnt_pre_reset", 32'(rx_frame_cnt), 32'(exp_fc));

    // Reset pulsed mid-frame around byte 20
    make_frame(64, 1'b0, fr);
    preamble();
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, fr[i]);
      it.d = fr[i]; it.sop = (i == 0); it.eop = 1'b0; it.len = '0;
      it.el = 1'b0; it.ec = 1'b0; it.fc = '0; it.ecn = '0; it.cyc = cyc;
      sb.push_back(it);
    end
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 32'(rx_valid), 32'd0);
    check_eq("mid_rst_eop", 32'(rx_eop), 32'd0);
    check_eq("mid_rst_frame_cnt", 32'(rx_frame_cnt), 32'd0);
    check_eq("mid_rst_err_cnt", 32'(rx_err_cnt), 32'd0);
    sb.delete();
    exp_fc = 0;
    exp_ec = 0;
    drive(1'b1, 8'h12);
    drive(1'b1, 8'h12);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b1, 8'h12);
    drive(1'b0, 8'h00);
    make_frame(64, 1'b0, fr); send_frame(fr, 2);
    drain("drain_final");
    check_eq("final_frame_cnt", 32'(rx_frame_cnt), 32'd1);
    check_eq("final_err_cnt", 32'(rx_err_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
